// File: rtl/dlx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dlx_pkg
// Brief    : Shared types and constants for the DLX fetch front end.
// Revision : 1.0
// ============================================================================
package dlx_pkg;

    localparam logic [0:31] DLX_NOP             = 32'h0;
    localparam int          FETCH_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [0:31] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous prefetch FIFO of {pc, inst}; flush beats push/pop.
// Revision : 1.0
// ============================================================================
module fetch_fifo
    import dlx_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int              c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_depth);
    assign w_do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_aw + 1)'(1);
                2'b01:   r_count <= r_count - (c_aw + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dlx_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : dlx_fetch_queue
// Brief    : DLX fetch front end: PC, req/ack imem port, prefetch FIFO to
//            decode, stall and redirect handling. Optional same-cycle bypass
//            of an acked word to decode when FETCH_BYPASS_EN is defined.
// Revision : 1.0
// ============================================================================
module dlx_fetch_queue
    import dlx_pkg::*;
#(
    parameter int          DEPTH    = FETCH_DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        initPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [0:31] imem_rdata,
    input  logic        branch_id,
    input  logic [31:0] branch_pc_id,
    input  logic        stall_id,
    output logic [0:31] inst_id,
    output logic [31:0] pcPlusFour_id,
    output logic        valid_id
);

    localparam int            c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0] c_depth = (c_aw + 1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_addr;
    logic          r_busy;
    logic          r_drop;

    logic          w_can_issue;
    logic          w_ack_ok;
    logic          w_accept;
    logic          w_consume;
    logic          w_push;
    logic          w_pop;
    fetch_entry_t  w_push_data;
    fetch_entry_t  w_head;
    logic [c_aw:0] w_count;
    logic          w_full;
    logic          w_empty;

    assign w_can_issue = !initPC && !r_busy && !branch_id && (w_count < c_depth);
    // Once raised, the request stays up (same address) until its ack, even
    // across a redirect; the redirected response is then dropped.
    assign imem_req    = !initPC && (r_busy || w_can_issue);
    assign imem_addr   = r_busy ? r_req_addr : r_fetch_pc;
    assign w_ack_ok    = imem_ack && imem_req;
    assign w_accept    = w_ack_ok && !r_drop && !branch_id;

`ifdef FETCH_BYPASS_EN
    assign w_consume   = w_accept && w_empty && !stall_id;
`else
    assign w_consume   = 1'b0;
`endif

    assign w_push      = w_accept && !w_consume;
    assign w_pop       = !initPC && !w_empty && !stall_id && !branch_id;
    assign w_push_data = '{pc: r_fetch_pc, inst: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (initPC),
        .flush     (branch_id),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_comb begin
        valid_id      = 1'b0;
        inst_id       = DLX_NOP;
        pcPlusFour_id = 32'h0;
        if (!initPC && !w_empty) begin
            valid_id      = 1'b1;
            inst_id       = w_head.inst;
            pcPlusFour_id = w_head.pc + 32'd4;
        end
`ifdef FETCH_BYPASS_EN
        else if (w_accept && w_empty) begin
            valid_id      = 1'b1;
            inst_id       = imem_rdata;
            pcPlusFour_id = r_fetch_pc + 32'd4;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (initPC) begin
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            if (w_ack_ok)         r_busy <= 1'b0;
            else if (w_can_issue) r_busy <= 1'b1;

            if (w_can_issue) r_req_addr <= r_fetch_pc;

            // An ack coinciding with the redirect is discarded directly.
            if (branch_id && r_busy && !w_ack_ok) r_drop <= 1'b1;
            else if (w_ack_ok)                    r_drop <= 1'b0;

            if (branch_id)     r_fetch_pc <= branch_pc_id;
            else if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    // Capacity is guaranteed by the issue rule; full only guards the push.
    logic w_unused_full;
    assign w_unused_full = w_full;

endmodule
`default_nettype wire

// File: tb/tb_dlx_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_dlx_fetch_queue
// Brief    : Self-checking bench for dlx_fetch_queue against a queue model.
// Revision : 1.0
// ============================================================================
module tb_dlx_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
    localparam int          FIRST_VALID = 0;
`else
    localparam int          FIRST_VALID = 1;
`endif

    logic        clk = 1'b0;
    logic        initPC = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [0:31] imem_rdata = '0;
    logic        branch_id = 1'b0;
    logic [31:0] branch_pc_id = '0;
    logic        stall_id = 1'b0;
    logic [0:31] inst_id;
    logic [31:0] pcPlusFour_id;
    logic        valid_id;

    always #5 clk = ~clk;

    dlx_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .initPC        (initPC),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .branch_id     (branch_id),
        .branch_pc_id  (branch_pc_id),
        .stall_id      (stall_id),
        .inst_id       (inst_id),
        .pcPlusFour_id (pcPlusFour_id),
        .valid_id      (valid_id)
    );

    // Reference model: prefetched words as a plain queue plus fetch bookkeeping.
    typedef struct { logic [31:0] pc; logic [0:31] inst; } ent_t;
    ent_t        q[$];
    logic [31:0] m_fpc = RESET_PC, m_haddr = RESET_PC;
    bit          m_out = 0, m_drop = 0;
    int          mem_rem = -1;

    int  k_lat_min = 0, k_lat_max = 0, k_stall_pct = 0, k_branch_pct = 0, k_reset_pm = 0;
    bit  k_spurious = 0;
    bit  f_branch = 0, f_reset = 0;
    logic [31:0] f_target = '0;
    int  errors = 0, checks = 0, cyc = 0;

    function automatic bit exp_req();
        return !initPC && (m_out || (q.size() < DEPTH && !branch_id));
    endfunction

    function automatic logic [97:0] model_out();
        bit r;
        logic v;
        logic [0:31] ins;
        logic [31:0] p4;
        r = exp_req(); v = 1'b0; ins = '0; p4 = '0;
        if (!initPC && q.size() > 0) begin
            v = 1'b1; ins = q[0].inst; p4 = q[0].pc + 32'd4;
        end
`ifdef FETCH_BYPASS_EN
        else if (r && imem_ack && !m_drop && !branch_id) begin
            v = 1'b1; ins = imem_rdata; p4 = m_fpc + 32'd4;
        end
`endif
        return {r, (r ? (m_out ? m_haddr : m_fpc) : 32'h0), v, ins, p4};
    endfunction

    task automatic model_update();
        bit r, issue, acc, keep, consume;
        logic [31:0] old_pc;
        if (initPC) begin
            q.delete(); m_fpc = RESET_PC; m_haddr = RESET_PC;
            m_out = 0; m_drop = 0; mem_rem = -1;
            return;
        end
        r = exp_req(); issue = r && !m_out; acc = r && imem_ack;
        keep = acc && !m_drop && !branch_id;
        consume = 0;
`ifdef FETCH_BYPASS_EN
        consume = keep && q.size() == 0 && !stall_id;
`endif
        old_pc = m_fpc;
        if (branch_id) q.delete();
        else if (q.size() > 0 && !stall_id) void'(q.pop_front());
        if (keep && !consume) q.push_back('{pc: old_pc, inst: imem_rdata});
        if (branch_id) m_fpc = branch_pc_id;
        else if (keep) m_fpc = old_pc + 32'd4;
        if (branch_id && m_out && !acc) m_drop = 1;
        else if (acc) m_drop = 0;
        if (issue) m_haddr = old_pc;
        if (acc) m_out = 0;
        else if (issue) m_out = 1;
        if (r && !acc && mem_rem > 0) mem_rem--;
    endtask

    // Drives one cycle of stimulus (memory agent reacts to the model's request).
    task automatic drive();
        bit r;
        initPC   = f_reset || ($urandom_range(999) < k_reset_pm);
        stall_id = ($urandom_range(99) < k_stall_pct);
        branch_id = ($urandom_range(99) < k_branch_pct);
        branch_pc_id = $urandom & 32'hFFFF_FFFC;
        if (f_branch) begin
            branch_id = 1'b1; branch_pc_id = f_target; stall_id = 1'b0; f_branch = 0;
        end
        r = exp_req();
        if (r && !m_out) mem_rem = $urandom_range(k_lat_max, k_lat_min);
        imem_ack   = r ? (mem_rem == 0) : (k_spurious && $urandom_range(9) == 0);
        imem_rdata = $urandom;
    endtask

    task automatic cycle(output logic [97:0] act, output logic [97:0] exp);
        drive();
        @(negedge clk);
        exp = model_out();
        act = {imem_req, (imem_req ? imem_addr : 32'h0), valid_id, inst_id, pcPlusFour_id};
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic knobs(int lmin, int lmax, int stall, int br, int rst_pm, bit spur);
        k_lat_min = lmin; k_lat_max = lmax; k_stall_pct = stall;
        k_branch_pct = br; k_reset_pm = rst_pm; k_spurious = spur;
    endtask

    task automatic test_reset();
        logic [97:0] a, e;
        knobs(0, 0, 0, 0, 0, 0);
        f_reset = 1;
        for (int i = 0; i < 3; i++) begin
            cycle(a, e);
            checks++;
            if (a !== e) begin errors++; $display("FAIL reset_model cyc=%0d actual=%h expected=%h", cyc, a, e); end
            checks++;
            if (a !== 98'h0) begin errors++; $display("FAIL reset_outputs cyc=%0d actual=%h expected=0", cyc, a); end
        end
        f_reset = 0;
    endtask

    task automatic test_zero_latency();
        logic [97:0] a, e;
        logic [31:0] addrs[$], pc4s[$];
        int first_valid = -1;
        knobs(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 24; i++) begin
            cycle(a, e);
            checks++;
            if (a !== e) begin errors++; $display("FAIL zero_lat cyc=%0d actual=%h expected=%h", cyc, a, e); end
            if (a[97]) addrs.push_back(a[96:65]);
            if (a[64]) begin pc4s.push_back(a[31:0]); if (first_valid < 0) first_valid = i; end
        end
        checks++;
        if (first_valid != FIRST_VALID) begin errors++; $display("FAIL first_valid_cycle actual=%0d expected=%0d", first_valid, FIRST_VALID); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (addrs.size() <= i || addrs[i] !== 32'(i * 4)) begin
                errors++; $display("FAIL req_addr_seq idx=%0d actual=%h expected=%h", i, (addrs.size() > i) ? addrs[i] : 32'hx, 32'(i * 4));
            end
            checks++;
            if (pc4s.size() <= i || pc4s[i] !== 32'(i * 4 + 4)) begin
                errors++; $display("FAIL pc4_seq idx=%0d actual=%h expected=%h", i, (pc4s.size() > i) ? pc4s[i] : 32'hx, 32'(i * 4 + 4));
            end
        end
    endtask

    task automatic test_stall_full();
        logic [97:0] a, e;
        int accepted = 0;
        logic [31:0] prev = 32'h0;
        knobs(0, 0, 100, 0, 0, 0);
        f_reset = 1; cycle(a, e); f_reset = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(a, e);
            checks++;
            if (a !== e) begin errors++; $display("FAIL stall_model cyc=%0d actual=%h expected=%h", cyc, a, e); end
            if (a[97] && imem_ack) accepted++;
            if (i == 9) begin
                checks++;
                if (a[97] !== 1'b0 || a[64] !== 1'b1) begin
                    errors++; $display("FAIL full_req_valid actual req=%b valid=%b expected req=0 valid=1", a[97], a[64]);
                end
            end
        end
        checks++;
        if (accepted != DEPTH) begin errors++; $display("FAIL buffered_count actual=%0d expected=%0d", accepted, DEPTH); end
        k_stall_pct = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(a, e);
            checks++;
            if (a !== e) begin errors++; $display("FAIL release_model cyc=%0d actual=%h expected=%h", cyc, a, e); end
            if (a[64]) begin
                checks++;
                if (a[31:0] !== prev + 32'd4) begin errors++; $display("FAIL release_order actual=%h expected=%h", a[31:0], prev + 32'd4); end
                prev = a[31:0];
            end
        end
    endtask

    task automatic test_latency3();
        logic [97:0] a, e;
        logic [31:0] prev_pc4 = 32'h0, held = 32'h0;
        bit pending = 0;
        knobs(3, 3, 20, 0, 0, 0);
        f_reset = 1; cycle(a, e); f_reset = 0;
        for (int i = 0; i < 80; i++) begin
            cycle(a, e);
            checks++;
            if (a !== e) begin errors++; $display("FAIL lat3_model cyc=%0d actual=%h expected=%h", cyc, a, e); end
            if (pending) begin
                checks++;
                if (a[97] !== 1'b1 || a[96:65] !== held) begin
                    errors++; $display("FAIL req_stable cyc=%0d actual req=%b addr=%h expected req=1 addr=%h", cyc, a[97], a[96:65], held);
                end
            end
            pending = a[97] && !imem_ack;
            held = a[96:65];
            if (a[64] && !stall_id) begin
                checks++;
                if (a[31:0] !== prev_pc4 + 32'd4) begin errors++; $display("FAIL lat3_order actual=%h expected=%h", a[31:0], prev_pc4 + 32'd4); end
                prev_pc4 = a[31:0];
            end
        end
    endtask

    task automatic test_redirect_outstanding();
        logic [97:0] a, e;
        int post = -1;
        bit seen_valid = 0;
        knobs(2, 2, 0, 0, 0, 0);
        f_reset = 1; cycle(a, e); f_reset = 0;
        for (int i = 0; i < 60; i++) begin
            if (post < 0 && m_out && m_haddr == 32'h10 && mem_rem == 1) begin
                f_branch = 1; f_target = 32'h100; post = 0;
            end else if (post >= 0) post++;
            cycle(a, e);
            checks++;
            if (a !== e) begin errors++; $display("FAIL redirect_model cyc=%0d actual=%h expected=%h", cyc, a, e); end
            if (post == 1) begin
                checks++;
                if (a[97] !== 1'b1 || a[96:65] !== 32'h10) begin errors++; $display("FAIL redirect_held actual req=%b addr=%h expected req=1 addr=00000010", a[97], a[96:65]); end
            end
            if (post == 2) begin
                checks++;
                if (a[97] !== 1'b1 || a[96:65] !== 32'h100) begin errors++; $display("FAIL redirect_target actual req=%b addr=%h expected req=1 addr=00000100", a[97], a[96:65]); end
            end
            if (post >= 1 && a[64] && !seen_valid) begin
                seen_valid = 1;
                checks++;
                if (a[31:0] !== 32'h104) begin errors++; $display("FAIL redirect_first_valid actual=%h expected=00000104", a[31:0]); end
            end
        end
        checks++;
        if (post < 0 || !seen_valid) begin errors++; $display("FAIL redirect_timeout actual post=%0d valid=%0d expected branch and valid", post, seen_valid); end
    endtask

    task automatic test_branch_ack_pop();
        logic [97:0] a, e;
        int post = -1;
        bit seen_valid = 0;
        knobs(1, 1, 100, 0, 0, 0);
        f_reset = 1; cycle(a, e); f_reset = 0;
        for (int i = 0; i < 40; i++) begin
            if (post < 0 && m_out && mem_rem == 0 && q.size() > 0) begin
                f_branch = 1; f_target = 32'h200; post = 0;
            end else if (post >= 0) post++;
            cycle(a, e);
            checks++;
            if (a !== e) begin errors++; $display("FAIL bap_model cyc=%0d actual=%h expected=%h", cyc, a, e); end
            if (post == 1) begin
                checks++;
                if (a[64] !== 1'b0 || a[97] !== 1'b1 || a[96:65] !== 32'h200) begin
                    errors++; $display("FAIL bap_flush actual valid=%b req=%b addr=%h expected valid=0 req=1 addr=00000200", a[64], a[97], a[96:65]);
                end
            end
            if (post >= 1 && a[64] && !seen_valid) begin
                seen_valid = 1;
                checks++;
                if (a[31:0] !== 32'h204) begin errors++; $display("FAIL bap_first_valid actual=%h expected=00000204", a[31:0]); end
            end
        end
        checks++;
        if (post < 0 || !seen_valid) begin errors++; $display("FAIL bap_timeout actual post=%0d valid=%0d expected branch and valid", post, seen_valid); end
    endtask

    task automatic test_random();
        logic [97:0] a, e;
        knobs(0, 3, 30, 5, 3, 1);
        f_reset = 1; cycle(a, e); f_reset = 0;
        for (int i = 0; i < 3000; i++) begin
            cycle(a, e);
            checks++;
            if (a !== e) begin errors++; $display("FAIL random cyc=%0d actual=%h expected=%h", cyc, a, e); end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_zero_latency();
        test_stall_full();
        test_latency3();
        test_redirect_outstanding();
        test_branch_ack_pop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
